// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
package gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CALC   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bus source and subtractor operand selects as seen by the datapath.
    localparam logic SEL_DATA = 1'b1;
    localparam logic SEL_SUB  = 1'b0;
    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_B    = 1'b1;

    localparam int DEF_ITER_W   = 8;
    localparam int DEF_MAX_ITER = 255;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction-step counter with clear and terminal-count flag.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int ITER_W   = DEF_ITER_W,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] cnt_q, cnt_d;

    // Holding at MAX_CNT keeps a stuck computation from wrapping past the timeout.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the 8-bit subtractive GCD datapath.
// Define GCD_TIMEOUT_EN to add the step counter and the err timeout exit.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int ITER_W   = DEF_ITER_W,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic gt,
    input  logic lt,
    input  logic eq,
    output logic ldA,
    output logic ldB,
    output logic sel_in,
    output logic sel1,
    output logic sel2,
    output logic busy,
    output logic done,
    output logic err
);

    state_t state_q, state_d;
    logic   timeout;

`ifdef GCD_TIMEOUT_EN
    logic tc;
    logic cnt_inc;
    logic err_q;

    assign cnt_inc = (state_q == ST_CALC) && !eq && !tc && (gt || lt);

    gcd_iter_counter #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_IDLE),
        .inc_i (cnt_inc),
        .tc_o  (tc)
    );

    assign timeout = tc;

    // Registered so err lines up with the DONE cycle that the timeout exit enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_CALC) && !eq && tc;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // NOTE: every output and state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        sel_in  = SEL_SUB;
        sel1    = SEL_A;
        sel2    = SEL_A;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                sel_in  = SEL_DATA;
                ldA     = 1'b1;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                sel_in  = SEL_DATA;
                ldB     = 1'b1;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                // Priority eq > timeout > gt > lt; the timeout exit loads nothing.
                if (eq || timeout) begin
                    state_d = ST_DONE;
                end else if (gt) begin
                    sel1 = SEL_A;
                    sel2 = SEL_B;
                    ldA  = 1'b1;
                end else if (lt) begin
                    sel1 = SEL_B;
                    sel2 = SEL_A;
                    ldB  = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench: gcd_controller driving a behavioural GCD datapath, checked against an arithmetic GCD model.
module tb_gcd_controller;

    localparam int MAX_ITER = 255;

    logic clk = 1'b0;
    logic rst, start;
    logic gt, lt, eq;
    logic ldA, ldB, sel_in, sel1, sel2, busy, done, err;

    logic [7:0] a_q = 8'd0;
    logic [7:0] b_q = 8'd0;
    logic [7:0] op_a, op_b, x, y, bus;

    int cyc = 0;
    int tests = 0;
    int failures = 0;
    logic prev_done = 1'b0;

    typedef struct {
        int         start_cyc;
        int         steps;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: host data bus or subtractor result feeds the A/B registers.
    assign x   = sel1 ? b_q : a_q;
    assign y   = sel2 ? b_q : a_q;
    assign bus = sel_in ? (ldA ? op_a : op_b) : (x - y);
    assign gt  = (a_q > b_q);
    assign lt  = (a_q < b_q);
    assign eq  = (a_q == b_q);

    always @(posedge clk) begin
        if (ldA) a_q <= bus;
        if (ldB) b_q <= bus;
    end

    gcd_controller dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .ldA    (ldA),
        .ldB    (ldB),
        .sel_in (sel_in),
        .sel1   (sel1),
        .sel2   (sel2),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: Euclid by repeated subtraction, capped at MAX_ITER steps.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int t);
        exp_t e;
        int ra = int'(a);
        int rb = int'(b);
        int n  = 0;
        while (ra != rb && n < MAX_ITER) begin
            if (ra > rb) ra -= rb;
            else         rb -= ra;
            n++;
        end
        e.start_cyc = t;
        e.steps     = n;
        e.res       = 8'(ra);
        e.err       = (ra != rb);
        return e;
    endfunction

    // Monitor: pops on every done pulse and checks protocol invariants each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", 32'(cyc - e.start_cyc), 32'(4 + e.steps));
                    check("result_a", 32'(a_q), 32'(e.res));
                    check("err_flag", 32'(err), 32'(e.err));
                    check("busy_at_done", 32'(busy), 32'd1);
                end
                check("done_no_load", 32'({ldA, ldB}), 32'd0);
                check("done_width", 32'(prev_done), 32'd0);
            end else begin
                check("err_without_done", 32'(err), 32'd0);
            end
            if (!busy) check("idle_quiet", 32'({ldA, ldB, sel_in, sel1, sel2, done, err}), 32'd0);
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issues start in the current (IDLE) cycle; returns at the negedge of cycle 1.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        wait_idle();
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        sb_q.push_back(model(a, b, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // {ldA, ldB, sel_in, sel1, sel2, busy, done} for cycles 1..6 of the 12/18 run.
    logic [6:0] trace [6];

    initial begin
        exp_t e;
        trace[0] = 7'b1010010;
        trace[1] = 7'b0110010;
        trace[2] = 7'b0101010;
        trace[3] = 7'b1000110;
        trace[4] = 7'b0000010;
        trace[5] = 7'b0000011;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = 8'd0;
        op_b  = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ldA, ldB, sel_in, sel1, sel2, busy, done, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(8'd12, 8'd18);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("trace_12_18_c%0d", k + 1),
                  32'({ldA, ldB, sel_in, sel1, sel2, busy, done}), 32'(trace[k]));
            @(negedge clk);
        end
        drain(20);

        launch(8'd7, 8'd7);     drain(20);
        launch(8'd255, 8'd1);   drain(300);
        launch(8'd0, 8'd0);     drain(20);

`ifdef GCD_TIMEOUT_EN
        launch(8'd0, 8'd5);     drain(300);
`else
        wait_idle();
        op_a  = 8'd0;
        op_b  = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("zero_operand_hang_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hang_reset_outputs", 32'({ldA, ldB, sel_in, sel1, sel2, busy, done, err}), 32'd0);
        @(negedge clk);
`endif

        // Reset in CALC cycle 4, then relaunch in cycle 6.
        launch(8'd12, 8'd18);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("mid_run_reset_outputs", 32'({ldA, ldB, sel_in, sel1, sel2, busy, done, err}), 32'd0);
        @(negedge clk);
        launch(8'd12, 8'd18);
        drain(20);

        repeat (20) begin
            launch(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
            drain(300);
        end

        // start held high: each run's cycle 0 follows the previous run's DONE cycle.
        wait_idle();
        start = 1'b1;
        for (int r = 0; r < 6; r++) begin
            op_a = 8'($urandom_range(1, 255));
            op_b = 8'($urandom_range(1, 40));
            e = model(op_a, op_b, cyc);
            sb_q.push_back(e);
            repeat (5 + e.steps) @(negedge clk);
        end
        start = 1'b0;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
